// File: rtl/prime_pkg.sv
// Shared types and constants for the prime checker LED output stage.
//   disp_state_t      : display FSM state (operand view / result view)
//   LED_COMPOSITE_PAT : logical LED pattern for a composite verdict (bit 0 lit)
//   LED_PRIME_ON      : logical LED pattern for the lit phase of the prime blink
// Both patterns are 32 bits wide. Users truncate them to their LED count.
package prime_pkg;

    typedef enum logic {
        SHOW_DATA = 1'b0,
        RESULT    = 1'b1
    } disp_state_t;

    localparam logic [31:0] LED_COMPOSITE_PAT = 32'b0001;
    localparam logic [31:0] LED_PRIME_ON      = '1;

endpackage

// File: rtl/prime_led_display_interval_timer.sv
// interval_timer: pulses tick_o for one cycle every PERIOD enabled cycles.
//   clk     in  : clock
//   rst_n   in  : asynchronous active-low reset
//   clear_i in  : restart the interval from zero (overrides en_i, suppresses tick)
//   en_i    in  : count this cycle
//   tick_o  out : combinational pulse on the cycle that completes an interval
module interval_timer #(
    parameter int unsigned PERIOD = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign tick_o    = en_i & ~clear_i & w_at_last;

    // The counter returns to zero on the completing cycle, so it never wraps
    // through values above PERIOD-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prime_led_display.sv
// prime_led_display: LED output stage behind the prime checker.
// Shows the operand while idle/busy. On a rising edge of valid_i it latches the
// verdict and shows a timed result pattern (blinking all-on for prime, bit 0
// solid for composite), then falls back to the operand.
//   clk              in  : clock
//   rst_n            in  : asynchronous active-low reset
//   data_i           in  : current operand [DATA_W]
//   valid_i          in  : checker result-valid level (low while busy)
//   prime_i          in  : checker verdict, used only on the start cycle
//   leds_o           out : registered physical LED drive [DATA_W]
//   showing_result_o out : high while a result pattern is displayed
module prime_led_display
    import prime_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned BLINK_HALF  = 12_500_000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              prime_i,
    output logic [DATA_W-1:0] leds_o,
    output logic              showing_result_o
);

    localparam logic [DATA_W-1:0] PAT_COMPOSITE = DATA_W'(LED_COMPOSITE_PAT);
    localparam logic [DATA_W-1:0] PAT_PRIME_ON  = DATA_W'(LED_PRIME_ON);

    disp_state_t       r_state;
    logic              r_valid_q;
    logic              r_prime_q;
    logic [DATA_W-1:0] r_data_q;
    logic              r_phase_on;
    logic [DATA_W-1:0] r_leds;
    logic              r_showing;

    disp_state_t       w_state_nxt;
    logic              w_prime_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_phase_nxt;
    logic [DATA_W-1:0] w_logical;
    logic [DATA_W-1:0] w_leds_nxt;
    logic              w_start;
    logic              w_in_result;
    logic              w_hold_tick;
    logic              w_blink_tick;

    // valid_q resets high so a checker that is already valid out of reset
    // does not count as a completion.
    assign w_start     = valid_i & ~r_valid_q;
    assign w_in_result = (r_state == RESULT);

    interval_timer #(.PERIOD(HOLD_CYCLES)) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (w_start),
        .en_i    (w_in_result),
        .tick_o  (w_hold_tick)
    );

    interval_timer #(.PERIOD(BLINK_HALF)) u_blink_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (w_start),
        .en_i    (w_in_result),
        .tick_o  (w_blink_tick)
    );

    // Next-state logic. Inside RESULT: new start > operand change > hold expiry.
    // The LED pattern is derived from the next-state values so that the
    // registered output matches the state it is entering.
    always_comb begin
        w_state_nxt = r_state;
        w_prime_nxt = r_prime_q;
        w_data_nxt  = r_data_q;
        w_phase_nxt = r_phase_on;
        w_logical   = data_i;

        if (w_start) begin
            w_state_nxt = RESULT;
            w_prime_nxt = prime_i;
            w_data_nxt  = data_i;
            w_phase_nxt = 1'b1;
        end else if (w_in_result) begin
            if (data_i != r_data_q) begin
                w_state_nxt = SHOW_DATA;
            end else if (w_hold_tick) begin
                w_state_nxt = SHOW_DATA;
            end else if (w_blink_tick) begin
                w_phase_nxt = ~r_phase_on;
            end
        end

        case (w_state_nxt)
            RESULT: begin
                if (w_prime_nxt) begin
                    w_logical = w_phase_nxt ? PAT_PRIME_ON : '0;
                end else begin
                    w_logical = PAT_COMPOSITE;
                end
            end
            default: w_logical = data_i;
        endcase

        w_leds_nxt = ACTIVE_LOW ? ~w_logical : w_logical;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SHOW_DATA;
            r_valid_q  <= 1'b1;
            r_prime_q  <= 1'b0;
            r_data_q   <= '0;
            r_phase_on <= 1'b1;
            r_leds     <= {DATA_W{ACTIVE_LOW}};
            r_showing  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid_q  <= valid_i;
            r_prime_q  <= w_prime_nxt;
            r_data_q   <= w_data_nxt;
            r_phase_on <= w_phase_nxt;
            r_leds     <= w_leds_nxt;
            r_showing  <= (w_state_nxt == RESULT);
        end
    end

    assign leds_o           = r_leds;
    assign showing_result_o = r_showing;

endmodule

// File: tb/tb_prime_led_display.sv
// Testbench for prime_led_display (DATA_W=4, HOLD_CYCLES=8, BLINK_HALF=2,
// ACTIVE_LOW=1). A behavioural model tracks the age of the current result and
// derives the expected logical pattern arithmetically from it.
module tb_prime_led_display;

    localparam int HOLD  = 8;
    localparam int BLINK = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] data_i;
    logic       valid_i;
    logic       prime_i;
    logic [3:0] leds_o;
    logic       showing_result_o;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit         m_res;
    bit         m_prime;
    bit         m_prev_v;
    int         m_age;
    logic [3:0] m_data;
    logic [3:0] m_phys;

    prime_led_display #(
        .DATA_W      (4),
        .HOLD_CYCLES (HOLD),
        .BLINK_HALF  (BLINK),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_i           (data_i),
        .valid_i          (valid_i),
        .prime_i          (prime_i),
        .leds_o           (leds_o),
        .showing_result_o (showing_result_o)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Model: one clock edge with the inputs currently applied.
    task automatic model_step();
        logic       start;
        logic [3:0] logical;
        if (!rst_n) begin
            m_res    = 1'b0;
            m_prev_v = 1'b1;
            m_phys   = 4'hF;
        end else begin
            start    = valid_i && !m_prev_v;
            m_prev_v = valid_i;
            if (start) begin
                m_res   = 1'b1;
                m_age   = 0;
                m_prime = prime_i;
                m_data  = data_i;
            end else if (m_res) begin
                if (data_i != m_data)      m_res = 1'b0;
                else if (m_age + 1 >= HOLD) m_res = 1'b0;
                else                        m_age++;
            end
            if (!m_res)        logical = data_i;
            else if (!m_prime) logical = 4'b0001;
            else               logical = (((m_age / BLINK) % 2) == 0) ? 4'hF : 4'h0;
            m_phys = ~logical;
        end
    endtask

    // driver: inputs change on the falling edge, checks 1 time unit after rise
    task automatic cycle_r(input logic [3:0] d, input logic v, input logic p, input logic r);
        @(negedge clk);
        data_i  = d;
        valid_i = v;
        prime_i = p;
        rst_n   = r;
        @(posedge clk);
        model_step();
        #1;
        check("leds", {28'b0, leds_o}, {28'b0, m_phys});
        check("showing", {31'b0, showing_result_o}, {31'b0, m_res});
    endtask

    task automatic cyc(input logic [3:0] d, input logic v, input logic p);
        cycle_r(d, v, p, 1'b1);
    endtask

    initial begin
        logic [3:0] d;
        logic       v;

        rst_n    = 1'b0;
        data_i   = 4'd5;
        valid_i  = 1'b1;
        prime_i  = 1'b0;
        m_res    = 1'b0;
        m_prime  = 1'b0;
        m_prev_v = 1'b1;
        m_age    = 0;
        m_data   = 4'd0;
        m_phys   = 4'hF;

        // reset with a checker already valid
        @(posedge clk);
        #1;
        check("rst_leds", {28'b0, leds_o}, 32'hF);
        check("rst_showing", {31'b0, showing_result_o}, 32'h0);
        cyc(4'd5, 1'b1, 1'b0);
        check("first_data", {28'b0, leds_o}, 32'b1010);

        // prime result: blink, full hold, back to operand
        cyc(4'd7, 1'b0, 1'b0);
        cyc(4'd7, 1'b1, 1'b1);
        check("prime_start", {28'b0, leds_o}, 32'b0000);
        for (int i = 0; i < 8; i++) cyc(4'd7, 1'b1, 1'b0);
        check("prime_after_hold", {28'b0, leds_o}, 32'b1000);

        // composite result
        cyc(4'd4, 1'b0, 1'b0);
        cyc(4'd4, 1'b1, 1'b0);
        check("comp_start", {28'b0, leds_o}, 32'b1110);
        for (int i = 0; i < 8; i++) cyc(4'd4, 1'b1, 1'b1);
        check("comp_after_hold", {28'b0, leds_o}, 32'b1011);

        // operand change cancels a prime result
        cyc(4'd7, 1'b0, 1'b0);
        cyc(4'd7, 1'b1, 1'b1);
        cyc(4'd7, 1'b1, 1'b0);
        cyc(4'd7, 1'b1, 1'b0);
        cyc(4'd8, 1'b1, 1'b0);
        check("cancel_leds", {28'b0, leds_o}, 32'b0111);
        check("cancel_showing", {31'b0, showing_result_o}, 32'h0);

        // composite result restarted by a new prime completion
        cyc(4'd4, 1'b0, 1'b0);
        cyc(4'd4, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(4'd4, 1'b1, 1'b0);
        cyc(4'd4, 1'b0, 1'b0);
        check("busy_keeps_result", {31'b0, showing_result_o}, 32'h1);
        cyc(4'd4, 1'b1, 1'b1);
        check("restart_prime_on", {28'b0, leds_o}, 32'b0000);
        for (int i = 0; i < 9; i++) cyc(4'd4, 1'b1, 1'b0);

        // async reset in the middle of a result
        cyc(4'd7, 1'b0, 1'b0);
        cyc(4'd7, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(4'd7, 1'b1, 1'b0);
        rst_n    = 1'b0;
        m_res    = 1'b0;
        m_prev_v = 1'b1;
        #1;
        check("async_rst_leds", {28'b0, leds_o}, 32'hF);
        check("async_rst_showing", {31'b0, showing_result_o}, 32'h0);
        cycle_r(4'd7, 1'b1, 1'b0, 1'b0);
        cyc(4'd7, 1'b1, 1'b0);
        check("no_replay", {28'b0, leds_o}, 32'b1000);

        // randomized traffic
        d = 4'd3;
        v = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0)  v = ~v;
            if ($urandom_range(0, 19) == 0) d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 399) == 0) begin
                cycle_r(d, v, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                cyc(d, v, 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
